// File: rtl/apb_uart_ctrl.sv
// APB3 register front-end and TX/RX sequencer for the UART datapath.
// Holds one transmit byte and launches it into UART_TX with a start/busy
// handshake; captures received bytes with overrun and framing-error tracking.
module apb_uart_ctrl #(
    parameter int DATA_BITS = 8
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [3:0]           PADDR,
    input  logic [31:0]          PWDATA,
    output logic [31:0]          PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic                 tx_start,
    output logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_busy,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_ready,
    input  logic                 rx_busy,
    input  logic                 frame_error,
    output logic                 irq
);

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_START     = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_DONE = 2'd3
    } tx_state_e;

    tx_state_e              state_q, state_d;
    logic [3:0]             ctrl_q, ctrl_d;
    logic [DATA_BITS-1:0]   tx_hold_q, tx_hold_d;
    logic [DATA_BITS-1:0]   rx_hold_q, rx_hold_d;
    logic                   tx_pending_q, tx_pending_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d;
    logic                   irq_q, irq_d;

    logic access, aligned, sel_tx, sel_rx, sel_status, sel_ctrl;
    logic err, wr_ok, rd_ok, rx_rd, rx_fire, tx_done;
    logic [31:0] status_word;

    // Address decode and error classification for the current ACCESS phase.
    // Reset gates the access so PRDATA/PSLVERR read 0 while PRESETn is low.
    always_comb begin
        access     = PSEL & PENABLE & PRESETn;
        aligned    = (PADDR[1:0] == 2'b00);
        sel_tx     = (PADDR[3:2] == 2'd0);
        sel_rx     = (PADDR[3:2] == 2'd1);
        sel_status = (PADDR[3:2] == 2'd2);
        sel_ctrl   = (PADDR[3:2] == 2'd3);
        err        = access & (~aligned
                               | (PWRITE & sel_rx)
                               | (PWRITE & sel_tx & (tx_pending_q | ~ctrl_q[0])));
        wr_ok      = access & PWRITE & ~err;
        rd_ok      = access & ~PWRITE & ~err;
        rx_rd      = rd_ok & sel_rx;
        rx_fire    = rx_ready & ctrl_q[1];
        tx_done    = (state_q == TX_WAIT_DONE) & ~tx_busy;
        status_word = {26'd0, tx_busy, rx_busy, frame_err_q, overrun_q,
                       tx_pending_q, rx_valid_q};
    end

    // Read mux; zero outside a good read so the bus sees 0 on errors too.
    always_comb begin
        PRDATA = 32'd0;
        if (rd_ok) begin
            case (PADDR[3:2])
                2'd1:    PRDATA = 32'(rx_hold_q);
                2'd2:    PRDATA = status_word;
                2'd3:    PRDATA = {28'd0, ctrl_q};
                default: PRDATA = 32'd0;
            endcase
        end
    end

    assign PSLVERR = err;
    assign PREADY  = 1'b1;
    assign tx_data = tx_hold_q;
    assign irq     = irq_q;

    // Register next-state: bus writes, RX capture, sticky flags, irq.
    // Hardware sets are applied after W1C clears so a same-cycle set wins.
    always_comb begin
        ctrl_d       = ctrl_q;
        tx_hold_d    = tx_hold_q;
        tx_pending_d = tx_pending_q;
        rx_hold_d    = rx_hold_q;
        rx_valid_d   = rx_valid_q;
        overrun_d    = overrun_q;
        frame_err_d  = frame_err_q;

        if (wr_ok && sel_ctrl)
            ctrl_d = PWDATA[3:0];
        if (wr_ok && sel_tx) begin
            tx_hold_d    = PWDATA[DATA_BITS-1:0];
            tx_pending_d = 1'b1;
        end
        if (tx_done)
            tx_pending_d = 1'b0;

        if (wr_ok && sel_status) begin
            if (PWDATA[2]) overrun_d   = 1'b0;
            if (PWDATA[3]) frame_err_d = 1'b0;
        end

        if (rx_rd)
            rx_valid_d = 1'b0;
        if (rx_fire) begin
            // A read completing this cycle frees the holding register.
            if (!rx_valid_q || rx_rd) begin
                rx_hold_d  = rx_data;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (frame_error && ctrl_q[1])
            frame_err_d = 1'b1;

        irq_d = (rx_valid_q & ctrl_q[2]) | ((overrun_q | frame_err_q) & ctrl_q[3]);
    end

    // Register state with asynchronous active-low reset.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_q       <= 4'h3;
            tx_hold_q    <= '0;
            tx_pending_q <= 1'b0;
            rx_hold_q    <= '0;
            rx_valid_q   <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            tx_hold_q    <= tx_hold_d;
            tx_pending_q <= tx_pending_d;
            rx_hold_q    <= rx_hold_d;
            rx_valid_q   <= rx_valid_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
            irq_q        <= irq_d;
        end
    end

    // TX sequencer state register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= TX_IDLE;
        else          state_q <= state_d;
    end

    // TX sequencer next state; tx_en only gates the launch, never an active frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE:      if (tx_pending_q && ctrl_q[0]) state_d = TX_START;
            TX_START:     state_d = TX_WAIT_BUSY;
            TX_WAIT_BUSY: if (tx_busy)  state_d = TX_WAIT_DONE;
            TX_WAIT_DONE: if (!tx_busy) state_d = TX_IDLE;
            default:      state_d = TX_IDLE;
        endcase
    end

    // TX sequencer outputs.
    always_comb begin
        tx_start = (state_q == TX_START);
    end

endmodule
